// File: rtl/in_port_arbiter.sv
// in_port_arbiter: round-robin scheduler that shares the single cache write
// path among all input modules. A granted port keeps the grant for its whole
// packet, and its beats, destination and source index are forwarded on one
// registered bus.
// Optional feature: define ARB_TIMEOUT_EN to enable the grant watchdog. When
// enabled, a port that is granted but stays silent for TIMEOUT cycles loses its
// grant, and timeout_err pulses for one cycle.
module in_port_arbiter #(
  parameter int PORT_NUM   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH_SEL  = $clog2(PORT_NUM),
  parameter int TIMEOUT    = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PORT_NUM-1:0]             req,
  input  logic [PORT_NUM-1:0]             in_vld,
  input  logic [PORT_NUM-1:0]             in_eop,
  input  logic [PORT_NUM*DATA_WIDTH-1:0]  in_data,
  input  logic [PORT_NUM*WIDTH_SEL-1:0]   in_rx,
  input  logic                            cache_full,
  output logic [PORT_NUM-1:0]             gnt,
  output logic                            full_out,
  output logic                            out_vld,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [WIDTH_SEL-1:0]            out_rx,
  output logic [WIDTH_SEL-1:0]            out_tx,
  output logic                            timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_e;

  state_e                  state_q, state_d;
  logic [WIDTH_SEL-1:0]    rrPtr_q, rrPtr_d;
  logic [WIDTH_SEL-1:0]    cur_q, cur_d;
  logic [PORT_NUM-1:0]     gnt_q, gnt_d;
  logic                    outVld_q, outVld_d;
  logic                    outSop_q, outSop_d;
  logic                    outEop_q, outEop_d;
  logic [DATA_WIDTH-1:0]   outData_q, outData_d;
  logic [WIDTH_SEL-1:0]    outRx_q, outRx_d;
  logic [WIDTH_SEL-1:0]    outTx_q, outTx_d;
  logic                    timeoutErr_d;

  logic                    winnerValid;
  logic [WIDTH_SEL-1:0]    winner;
  logic                    curVld;
  logic                    curEop;
  logic [DATA_WIDTH-1:0]   curData;
  logic [WIDTH_SEL-1:0]    curRx;
  logic [WIDTH_SEL-1:0]    nextPtr;
  logic                    startGrant;
  logic                    timeoutHit;

  assign curVld     = in_vld[cur_q];
  assign curEop     = in_eop[cur_q];
  assign curData    = in_data[cur_q*DATA_WIDTH +: DATA_WIDTH];
  assign curRx      = in_rx[cur_q*WIDTH_SEL +: WIDTH_SEL];
  assign nextPtr    = (cur_q == WIDTH_SEL'(PORT_NUM-1)) ? '0 : cur_q + 1'b1;
  assign startGrant = (|req) && !cache_full;
  assign full_out   = cache_full;

  // Pick the first requesting port at or above rrPtr, wrapping back to port 0.
  always_comb begin
    int idx;
    winnerValid = 1'b0;
    winner      = '0;
    idx         = 0;
    for (int k = 0; k < PORT_NUM; k++) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= PORT_NUM) idx = idx - PORT_NUM;
      if (!winnerValid && req[idx]) begin
        winnerValid = 1'b1;
        winner      = WIDTH_SEL'(idx);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] timer_q;
  logic          timeoutErr_q;

  assign timeoutHit  = (state_q != IDLE) && !curVld && (timer_q == TW'(TIMEOUT-1));
  assign timeout_err = timeoutErr_q;

  // Watchdog counts silent cycles while a grant is held, cleared by every beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q      <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      timeoutErr_q <= timeoutErr_d;
      if (state_q == IDLE || curVld) timer_q <= '0;
      else                           timer_q <= timer_q + 1'b1;
    end
  end
`else
  assign timeoutHit  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: hold the grant until the eop beat (or a watchdog revoke).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (startGrant) state_d = GRANT;
      GRANT: begin
        if (curVld)          state_d = curEop ? IDLE : XFER;
        else if (timeoutHit) state_d = IDLE;
      end
      XFER: begin
        if (curVld && curEop) state_d = IDLE;
        else if (timeoutHit)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: grant vector, pointers and the forwarded beat.
  always_comb begin
    gnt_d        = gnt_q;
    cur_d        = cur_q;
    rrPtr_d      = rrPtr_q;
    outVld_d     = 1'b0;
    outSop_d     = 1'b0;
    outEop_d     = 1'b0;
    outData_d    = outData_q;
    outRx_d      = outRx_q;
    outTx_d      = outTx_q;
    timeoutErr_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (startGrant && winnerValid) begin
          gnt_d[winner] = 1'b1;
          cur_d         = winner;
        end
      end
      GRANT, XFER: begin
        if (curVld) begin
          outVld_d  = 1'b1;
          outSop_d  = (state_q == GRANT);
          outEop_d  = curEop;
          outData_d = curData;
          if (state_q == GRANT) begin
            outRx_d = curRx;
            outTx_d = cur_q;
          end
          if (curEop) begin
            gnt_d   = '0;
            rrPtr_d = nextPtr;
          end
        end else if (timeoutHit) begin
          gnt_d        = '0;
          rrPtr_d      = nextPtr;
          timeoutErr_d = 1'b1;
        end
      end
      default: gnt_d = '0;
    endcase
  end

  // Datapath registers; reset drops any packet in flight without an eop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q   <= '0;
      cur_q     <= '0;
      gnt_q     <= '0;
      outVld_q  <= 1'b0;
      outSop_q  <= 1'b0;
      outEop_q  <= 1'b0;
      outData_q <= '0;
      outRx_q   <= '0;
      outTx_q   <= '0;
    end else begin
      rrPtr_q   <= rrPtr_d;
      cur_q     <= cur_d;
      gnt_q     <= gnt_d;
      outVld_q  <= outVld_d;
      outSop_q  <= outSop_d;
      outEop_q  <= outEop_d;
      outData_q <= outData_d;
      outRx_q   <= outRx_d;
      outTx_q   <= outTx_d;
    end
  end

  assign gnt      = gnt_q;
  assign out_vld  = outVld_q;
  assign out_sop  = outSop_q;
  assign out_eop  = outEop_q;
  assign out_data = outData_q;
  assign out_rx   = outRx_q;
  assign out_tx   = outTx_q;

endmodule

// File: doc/in_port_arbiter.md
# in_port_arbiter

Round-robin scheduler sharing the single shared-cache write path among all input modules. Each input module raises a request when a packet is queued in its dual-clock FIFO; the arbiter grants one port at a time (driving that port's `ready_in`), holds the grant for the whole packet, and forwards the granted port's beats, destination (`rx`) and source (`tx`) to the cache write side on a single registered bus. Sits in the internal clock domain between the input-module array and the shared cache write controller.

## Interface
- `PORT_NUM`, 16, number of input modules arbitrated (matches `PORT_NUB_TOTAL`)
- `DATA_WIDTH`, 32, beat width (matches `DATA_WIDTH`)
- `WIDTH_SEL`, `$clog2(PORT_NUM)`, port index width
- `TIMEOUT`, 1024, watchdog limit in cycles (used only with `ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  internal clock; one clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  PORT_NUM  per-port packet-pending request
- `in_vld`  in  PORT_NUM  per-port beat valid (input module `vld`)
- `in_eop`  in  PORT_NUM  per-port last-beat flag, qualified by `in_vld`
- `in_data`  in  PORT_NUM*DATA_WIDTH  per-port beat; port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `in_rx`  in  PORT_NUM*WIDTH_SEL  per-port destination; port i at [i*WIDTH_SEL +: WIDTH_SEL]
- `cache_full`  in  1  shared cache cannot accept a new packet
- `gnt`  out  PORT_NUM  one-hot grant, wired to each port's `ready_in`
- `full_out`  out  1  `cache_full` broadcast to every port's `full_in`
- `out_vld`  out  1  forwarded beat valid
- `out_sop`  out  1  first beat of packet
- `out_eop`  out  1  last beat of packet
- `out_data`  out  DATA_WIDTH  forwarded beat
- `out_rx`  out  WIDTH_SEL  destination of current packet
- `out_tx`  out  WIDTH_SEL  source port index of current packet
- `timeout_err`  out  1  one-cycle pulse on watchdog revoke (tied 0 without macro)

## Operation
- FSM states: IDLE, GRANT, XFER.
- IDLE: if `|req && !cache_full`, select winner = first set `req` bit searching upward from `rr_ptr`, wrapping PORT_NUM-1→0; register `gnt` = one-hot(winner), latch `cur` = winner; go to GRANT. Otherwise stay, `gnt` = 0.
- GRANT: wait for `in_vld[cur]`. On it: forward beat with `out_sop`=1, latch `out_rx` = `in_rx[cur]`; if `in_eop[cur]` also set, go to IDLE, else go to XFER.
- XFER: forward every `in_vld[cur]` beat (`out_sop`=0); on `in_vld[cur] && in_eop[cur]` forward with `out_eop`=1, clear `gnt`, go to IDLE.
- Returning to IDLE: `rr_ptr` = cur+1 modulo PORT_NUM (wrap at PORT_NUM-1 → 0).
- `req` is sampled only in IDLE; deassertion of `req[cur]` after grant is ignored — grant holds until eop.
- `in_vld` of non-granted ports is ignored; no beat from them reaches the output.
- `cache_full` blocks only new grants; a packet in flight completes. `full_out` = `cache_full` combinationally.
- `out_tx` = `cur`, `out_rx` held constant for the whole packet.

## Timing
- Reset (async): state IDLE, `rr_ptr`=0, `cur`=0, `gnt`=0, `out_vld`=0, `out_sop`=0, `out_eop`=0, `out_data`=0, `out_rx`=0, `out_tx`=0, `timeout_err`=0. Reset mid-packet drops the packet; no partial eop is emitted.
- `req` to `gnt`: 1 cycle (gnt registered on the edge where IDLE sees the request).
- Input beat to output beat: 1 cycle; all `out_*` registered; beat rate up to 1 per cycle, no bubbles inserted.
- Eop beat in cycle N: `gnt` low in cycle N+1; next grant earliest cycle N+2 (one IDLE cycle).
- Single-beat packet (sop and eop same beat): `out_sop`=`out_eop`=1 same cycle.

## Configuration
- `ARB_TIMEOUT_EN` defined: a counter runs in GRANT and XFER, reset on each `in_vld[cur]` beat; reaching TIMEOUT cycles without a beat clears `gnt`, pulses `timeout_err` for 1 cycle, advances `rr_ptr`, returns to IDLE with no `out_eop` emitted.
- Not defined: no counter, grant held indefinitely, `timeout_err` constant 0.

## Test plan
- Reset, `req`=0x0004, port 2 sends 3 beats (0xA0,0xA1,0xA2 eop), `in_rx`=5 -> `gnt`=0x0004 next cycle; `out_data` A0/A1/A2 with sop on A0, eop on A2, `out_tx`=2, `out_rx`=5.
- `req`=0xFFFF held, 1-beat packets -> grant order 0,1,…,15,0; each grant gap exactly 2 cycles after eop.
- `cache_full`=1 with `req`=0x0001 -> `gnt` stays 0; drop `cache_full` -> `gnt`=0x0001 next cycle; `cache_full` raised mid-packet -> packet completes.
- Port 3 granted, port 7 drives `in_vld` with 0xDEAD -> 0xDEAD never appears on `out_data`.
- `rst_n` pulled low after 2 of 4 beats -> all outputs 0 immediately, no `out_eop`; next arbitration starts from port 0.
- With `ARB_TIMEOUT_EN`, TIMEOUT=16, granted port silent -> `timeout_err` pulse 16 cycles after grant, `gnt`=0, next requester granted.
